// File: rtl/neptune_disp_pkg.sv
// Shared widths, event record and FSM state type for the display event capture path.
package neptune_disp_pkg;

    localparam int ENTITY_W = 3;
    localparam int ADD_W    = 20;
    localparam int DATA_W   = 21;
    localparam int DWELL_W  = 24;

    typedef struct packed {
        logic [ENTITY_W-1:0] entity;
        logic [ADD_W-1:0]    add;
        logic [DATA_W-1:0]   data;
    } disp_evt_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_cap_state_e;

endpackage

// File: rtl/disp_evt_fifo.sv
// Synchronous event FIFO; pointers carry an extra MSB so full and empty are distinguishable.
module disp_evt_fifo
    import neptune_disp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  disp_evt_t        din_i,
    output disp_evt_t        head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   level_o
);

    disp_evt_t        mem_q [DEPTH];
    logic [PTR_W:0]   wptr_q;
    logic [PTR_W:0]   rptr_q;

    assign level_o = wptr_q - rptr_q;
    assign full_o  = (level_o == (PTR_W+1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + (PTR_W+1)'(1);
            if (pop_i)  rptr_q <= rptr_q + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[PTR_W-1:0]] <= din_i;
    end

endmodule

// File: rtl/display_event_capture.sv
// Queues bus events and presents each to the display driver for a minimum dwell time.
// Optional DISP_COALESCE_EN: drop an event identical to the last accepted one.
module display_event_capture
    import neptune_disp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DWELL = 5000000,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ev_valid,
    input  logic [ENTITY_W-1:0] ev_entity,
    input  logic [ADD_W-1:0]    ev_add,
    input  logic [DATA_W-1:0]   ev_data,
    input  logic                freeze,
    input  logic                clr_ovf,
    output logic [ENTITY_W-1:0] entity_out,
    output logic [ADD_W-1:0]    add_out,
    output logic [DATA_W-1:0]   data_out,
    output logic                disp_valid,
    output logic                overflow,
    output logic [PTR_W:0]      level
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

    disp_evt_t          ev_in;
    disp_evt_t          head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               drop;
    logic               coalesced;

    disp_cap_state_e    state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    disp_evt_t          out_q, out_d;
    logic               dv_q, dv_d;
    logic               ovf_q, ovf_d;

    assign ev_in = '{entity: ev_entity, add: ev_add, data: ev_data};

`ifdef DISP_COALESCE_EN
    disp_evt_t last_q;
    logic      last_vld_q;

    assign coalesced = last_vld_q && (ev_in == last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_q     <= ev_in;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign coalesced = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = ev_valid && !coalesced && (!full || pop);
    assign drop = ev_valid && !coalesced && full && !pop;

    disp_evt_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (ev_in),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        dv_d    = dv_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: pop = !empty;
            SHOW: begin
                if (!freeze) begin
                    if (cnt_q != '0) cnt_d = cnt_q - DWELL_W'(1);
                    else if (!empty) pop = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            out_d   = head;
            dv_d    = 1'b1;
            cnt_d   = DWELL_LOAD;
            state_d = SHOW;
        end
    end

    // A drop in the same cycle as clr_ovf keeps the flag set.
    assign ovf_d = drop | (ovf_q & ~clr_ovf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign entity_out = out_q.entity;
    assign add_out    = out_q.add;
    assign data_out   = out_q.data;
    assign disp_valid = dv_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_display_event_capture.sv
// Bench for display_event_capture: directed scenarios plus random traffic against a queue-based model.
module tb_display_event_capture;
    import neptune_disp_pkg::*;

    localparam int DEPTH = 4;
    localparam int DWELL = 8;
    localparam int PTR_W = 2;
`ifdef DISP_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                ev_valid = 1'b0;
    logic [ENTITY_W-1:0] ev_entity = '0;
    logic [ADD_W-1:0]    ev_add = '0;
    logic [DATA_W-1:0]   ev_data = '0;
    logic                freeze = 1'b0;
    logic                clr_ovf = 1'b0;
    logic [ENTITY_W-1:0] entity_out;
    logic [ADD_W-1:0]    add_out;
    logic [DATA_W-1:0]   data_out;
    logic                disp_valid;
    logic                overflow;
    logic [PTR_W:0]      level;

    always #5 clk = ~clk;

    display_event_capture #(.DEPTH(DEPTH), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev_valid   (ev_valid),
        .ev_entity  (ev_entity),
        .ev_add     (ev_add),
        .ev_data    (ev_data),
        .freeze     (freeze),
        .clr_ovf    (clr_ovf),
        .entity_out (entity_out),
        .add_out    (add_out),
        .data_out   (data_out),
        .disp_valid (disp_valid),
        .overflow   (overflow),
        .level      (level)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: pending events, what is on display and how many cycles it still owes.
    disp_evt_t mq[$];
    disp_evt_t m_disp;
    bit        m_dv, m_ovf, m_show, m_last_v;
    int        m_left;
    disp_evt_t m_last;

    function automatic disp_evt_t mk(input logic [2:0] en, input logic [19:0] ad, input logic [20:0] da);
        disp_evt_t r;
        r.entity = en;
        r.add    = ad;
        r.data   = da;
        return r;
    endfunction

    function automatic logic [48:0] dut_snap();
        return {entity_out, add_out, data_out, disp_valid, overflow, level};
    endfunction

    function automatic logic [48:0] mdl_snap();
        return {m_disp, m_dv, m_ovf, 3'(mq.size())};
    endfunction

    function automatic disp_evt_t shown();
        return mk(entity_out, add_out, data_out);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_disp = '0; m_dv = 0; m_ovf = 0; m_show = 0; m_left = 0;
        m_last = '0; m_last_v = 0;
    endtask

    task automatic model_edge(input bit v, input disp_evt_t e, input bit frz, input bit clr);
        int sz;
        bit pop, match, acc, drp;
        sz  = mq.size();
        pop = 0;
        if (!m_show) pop = (sz > 0);
        else if (!frz && m_left == 1) pop = (sz > 0);
        match = COAL && m_last_v && (e == m_last);
        acc = v && !match && (sz < DEPTH || pop);
        drp = v && !match && (sz == DEPTH) && !pop;
        if (pop) begin
            m_disp = mq.pop_front();
            m_dv = 1; m_show = 1; m_left = DWELL;
        end else if (m_show && !frz) begin
            if (m_left == 1) m_show = 0;
            else m_left--;
        end
        if (acc) begin
            mq.push_back(e);
            m_last = e; m_last_v = 1;
        end
        if (drp) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic step(input bit v, input disp_evt_t e, input bit frz, input bit clr);
        ev_valid = v; ev_entity = e.entity; ev_add = e.add; ev_data = e.data;
        freeze = frz; clr_ovf = clr;
        @(posedge clk);
        model_edge(v, e, frz, clr);
        #1;
        ev_valid = 0; freeze = 0; clr_ovf = 0;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_snap() !== 49'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_snap());
        end
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0);
            n_cmp++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++; $display("FAIL reset_idle: got %h want %h", dut_snap(), mdl_snap());
            end
        end
    endtask

    task automatic test_single();
        disp_evt_t a;
        a = mk(3'd3, 20'h01234, 21'h00ABC);
        step(1, a, 0, 0);
        n_cmp++;
        if (level !== 3'd1 || disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_push: level=%0d dv=%b want 1/0", level, disp_valid);
        end
        step(0, '0, 0, 0);
        n_cmp++;
        if (shown() !== a || level !== 3'd0 || disp_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_present: got %h lvl=%0d dv=%b want %h 0 1", shown(), level, disp_valid, a);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, '0, 0, 0);
            n_cmp++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++; $display("FAIL single_hold: got %h want %h", dut_snap(), mdl_snap());
            end
        end
        n_cmp++;
        if (shown() !== a) begin
            n_fail++; $display("FAIL single_after_idle: got %h want %h", shown(), a);
        end
    endtask

    task automatic test_overflow();
        disp_evt_t evs[6];
        disp_evt_t seen[$];
        int held[$];
        for (int i = 0; i < 6; i++)
            evs[i] = mk(3'($urandom), {4'hA, 12'($urandom), 4'(i)}, 21'($urandom));
        for (int i = 0; i < 6; i++) begin
            step(1, evs[i], 0, 0);
            n_cmp++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++; $display("FAIL ovf_fill: got %h want %h", dut_snap(), mdl_snap());
            end
        end
        n_cmp++;
        if (overflow !== 1'b1 || level !== 3'd4) begin
            n_fail++; $display("FAIL ovf_set: ovf=%b level=%0d want 1/4", overflow, level);
        end
        for (int i = 0; i < 45; i++) begin
            step(0, '0, 0, 0);
            if (seen.size() == 0 || shown() !== seen[seen.size()-1]) begin
                seen.push_back(shown()); held.push_back(1);
            end else held[held.size()-1]++;
            n_cmp++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++; $display("FAIL ovf_drain: got %h want %h", dut_snap(), mdl_snap());
            end
        end
        n_cmp++;
        if (seen.size() != 5) begin
            n_fail++; $display("FAIL ovf_seq_len: got %0d want 5", seen.size());
        end
        for (int k = 0; k < seen.size() && k < 5; k++) begin
            n_cmp++;
            if (seen[k] !== evs[k]) begin
                n_fail++; $display("FAIL ovf_seq[%0d]: got %h want %h", k, seen[k], evs[k]);
            end
            if (k >= 1 && k <= 3) begin
                n_cmp++;
                if (held[k] != DWELL) begin
                    n_fail++; $display("FAIL ovf_dwell[%0d]: got %0d want %0d", k, held[k], DWELL);
                end
            end
        end
        step(0, '0, 0, 1);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_freeze();
        disp_evt_t a, b, c, nxt;
        int hold_a;
        bit got_nxt;
        a = mk(3'd1, 20'hB0001, 21'h012345);
        b = mk(3'd2, 20'hB0002, 21'h1FFFFF);
        c = mk(3'd4, 20'hB0003, 21'h000007);
        hold_a = 0; got_nxt = 0; nxt = '0;
        step(1, a, 0, 0);
        step(1, b, 0, 0);
        if (shown() === a) hold_a++;
        for (int i = 0; i < 53; i++) begin
            if (i < 3) step(0, '0, 0, 0);
            else if (i < 23) step(i == 10, c, 1, 0);
            else step(0, '0, 0, 0);
            if (i == 10) begin
                n_cmp++;
                if (level !== 3'd2) begin
                    n_fail++; $display("FAIL freeze_push: level=%0d want 2", level);
                end
            end
            if (shown() === a) hold_a++;
            else if (!got_nxt) begin nxt = shown(); got_nxt = 1; end
            n_cmp++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++; $display("FAIL freeze_model: got %h want %h", dut_snap(), mdl_snap());
            end
        end
        n_cmp++;
        if (hold_a != DWELL + 20) begin
            n_fail++; $display("FAIL freeze_hold: got %0d want %0d", hold_a, DWELL + 20);
        end
        n_cmp++;
        if (nxt !== b) begin
            n_fail++; $display("FAIL freeze_next: got %h want %h", nxt, b);
        end
    endtask

    task automatic test_full_pop();
        disp_evt_t e;
        bit found;
        for (int i = 0; i < 5; i++)
            step(1, mk(3'(i), {4'hC, 12'($urandom), 4'(i)}, 21'($urandom)), 0, 0);
        n_cmp++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL fullpop_fill: level=%0d ovf=%b want 4/0", level, overflow);
        end
        e = mk(3'd6, 20'hC00FF, 21'h0A0A0A);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_show && m_left == 1 && mq.size() == DEPTH) begin
                step(1, e, 0, 0);
                found = 1;
            end else step(0, '0, 0, 0);
        end
        n_cmp++;
        if (!found) begin
            n_fail++; $display("FAIL fullpop_timeout: got no expiry want expiry within 20 cycles");
        end
        n_cmp++;
        if (level !== 3'd4 || overflow !== 1'b0 || dut_snap() !== mdl_snap()) begin
            n_fail++; $display("FAIL fullpop_push: level=%0d ovf=%b want 4/0", level, overflow);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, '0, 0, 0);
            if (mq.size() == 3) found = 1;
        end
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        n_cmp++;
        if (!found || level !== 3'd3) begin
            n_fail++; $display("FAIL midrst_setup: level=%0d want 3", level);
        end
        #2 rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_snap() !== 49'h0) begin
            n_fail++; $display("FAIL midrst_zero: got %h want 0", dut_snap());
        end
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            step(0, '0, 0, 0);
            n_cmp++;
            if (level !== 3'd0 || disp_valid !== 1'b0 || dut_snap() !== 49'h0) begin
                n_fail++; $display("FAIL midrst_idle: got %h want 0", dut_snap());
            end
        end
        step(1, mk(3'd7, 20'h0D00D, 21'h000123), 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, '0, 0, 0);
            n_cmp++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++; $display("FAIL midrst_after: got %h want %h", dut_snap(), mdl_snap());
            end
        end
    endtask

    task automatic test_coalesce();
        disp_evt_t x, ii, d;
        logic [PTR_W:0] exp_lvl;
        x  = mk(3'd5, 20'h0ABCD, 21'h000001);
        ii = mk(3'd1, 20'h00010, 21'h100000);
        d  = mk(3'd2, 20'h00020, 21'h000005);
        exp_lvl = COAL ? 3'd2 : 3'd4;
        step(1, x, 0, 0);
        step(1, ii, 0, 0);
        step(1, ii, 0, 0);
        step(1, ii, 0, 0);
        step(1, d, 0, 0);
        n_cmp++;
        if (level !== exp_lvl || overflow !== 1'b0) begin
            n_fail++; $display("FAIL coalesce_level: level=%0d ovf=%b want %0d/0", level, overflow, exp_lvl);
        end
        for (int i = 0; i < 50; i++) begin
            step(0, '0, 0, 0);
            n_cmp++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++; $display("FAIL coalesce_drain: got %h want %h", dut_snap(), mdl_snap());
            end
        end
    endtask

    task automatic test_random();
        disp_evt_t pool[4];
        for (int k = 0; k < 4; k++)
            pool[k] = mk(3'($urandom), 20'($urandom), 21'($urandom));
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 45, pool[$urandom_range(0, 3)],
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 5);
            n_cmp++;
            if (dut_snap() !== mdl_snap()) begin
                n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_snap(), mdl_snap());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_overflow();
        test_freeze();
        test_full_pop();
        test_mid_reset();
        test_coalesce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
